// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the MCP3202-style SPI ADC responder.
package adc_spi_pkg;

    localparam int DATA_W_DEFAULT = 12;

    // Config bits arrive SGL/DIFF, ODD/SIGN, MSBF and are shifted in from the LSB.
    localparam int CFG_BITS     = 3;
    localparam int CFG_SGL_IDX  = 2;
    localparam int CFG_ODD_IDX  = 1;
    localparam int CFG_MSBF_IDX = 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CFG,
        DATA_MSB,
        DATA_LSB,
        DONE
    } state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI link plus sample/conversion side-band between the AUDIO master and the responder.
interface adc_spi_responder_if
    import adc_spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              adc_clk;
    logic              adc_cs;
    logic              adc_mosi;
    logic              adc_miso;
    logic              adc_miso_oe;
    logic [DATA_W-1:0] sample_ch0;
    logic [DATA_W-1:0] sample_ch1;
    logic              conv_valid;
    logic              conv_ch;
    logic              conv_diff;
    logic [DATA_W-1:0] conv_data;
    logic              proto_err;

    modport master (
        output adc_clk, adc_cs, adc_mosi, sample_ch0, sample_ch1,
        input  adc_miso, adc_miso_oe, conv_valid, conv_ch, conv_diff, conv_data, proto_err
    );

    modport slave (
        input  adc_clk, adc_cs, adc_mosi, sample_ch0, sample_ch1,
        output adc_miso, adc_miso_oe, conv_valid, conv_ch, conv_diff, conv_data, proto_err
    );

endinterface

// File: rtl/adc_spi_responder_edge_sync.sv
// N-stage synchronizer with single-clk rise/fall pulses on the synchronized level.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Reset to the line's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// MCP3202-style 2-channel ADC emulated as an SPI target, oversampling the link on clk.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 reset,
    adc_spi_responder_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    logic w_clk_level, w_clk_rise, w_clk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.adc_clk),
        .o_level (w_clk_level),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.adc_cs),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    assign w_unused = ^{w_clk_level, w_cs_rise, w_cs_fall};

    // MOSI uses the same depth so it lines up with the detected clock edge.
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    always_ff @(posedge clk) begin
        if (reset) r_mosi_sync <= '0;
        else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.adc_mosi};
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    function automatic logic [DATA_W-1:0] clamp_diff(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        logic [DATA_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[DATA_W] ? '0 : d[DATA_W-1:0];
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CFG_BITS-1:0] r_cfg;
    logic [DATA_W-1:0]   r_sample;
    logic                r_miso, r_oe;
    logic                r_conv_valid, r_conv_ch, r_conv_diff, r_proto_err;
    logic [DATA_W-1:0]   r_conv_data;

    logic [CFG_BITS-1:0] w_cfg_next;
    logic [DATA_W-1:0]   w_sample;
    logic [CNT_W-1:0]    w_msb_idx;

    always_comb begin
        w_cfg_next = {r_cfg[CFG_BITS-2:0], w_mosi};
        w_msb_idx  = CNT_W'(DATA_W - 1) - r_cnt;
        if (w_cfg_next[CFG_SGL_IDX])
            w_sample = w_cfg_next[CFG_ODD_IDX] ? bus.sample_ch1 : bus.sample_ch0;
        else
            w_sample = w_cfg_next[CFG_ODD_IDX] ? clamp_diff(bus.sample_ch1, bus.sample_ch0)
                                               : clamp_diff(bus.sample_ch0, bus.sample_ch1);
    end

    always_ff @(posedge clk) begin
        // NOTE: r_sample is an ordinary register, reset with the rest so no stale data leaks out.
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cfg        <= '0;
            r_sample     <= '0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_conv_valid <= 1'b0;
            r_conv_ch    <= 1'b0;
            r_conv_diff  <= 1'b0;
            r_conv_data  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_conv_valid <= 1'b0;
            r_proto_err  <= 1'b0;
            if (r_state != IDLE && w_cs_level) begin
                r_state     <= IDLE;
                r_oe        <= 1'b0;
                r_miso      <= 1'b0;
                r_proto_err <= (r_state == CFG) || (r_state == DATA_MSB);
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_cs_level) begin
                            r_state <= WAIT_START;
                            r_oe    <= 1'b1;
                            r_miso  <= 1'b0;
                        end
                    end
                    WAIT_START: begin
                        if (w_clk_rise && w_mosi) begin
                            r_state <= CFG;
                            r_cnt   <= '0;
                        end
                    end
                    CFG: begin
                        // r_cnt == 3 means all config bits are in and the null bit is pending.
                        if (w_clk_rise && r_cnt < CNT_W'(CFG_BITS)) begin
                            r_cfg <= w_cfg_next;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(CFG_BITS - 1)) r_sample <= w_sample;
                        end else if (w_clk_fall && r_cnt == CNT_W'(CFG_BITS)) begin
                            r_miso  <= 1'b0;
                            r_state <= DATA_MSB;
                            r_cnt   <= '0;
                        end
                    end
                    DATA_MSB: begin
                        if (w_clk_fall) begin
                            r_miso <= r_sample[w_msb_idx];
                            if (r_cnt == CNT_W'(DATA_W - 1)) begin
                                r_conv_valid <= 1'b1;
                                r_conv_ch    <= r_cfg[CFG_ODD_IDX];
                                r_conv_diff  <= ~r_cfg[CFG_SGL_IDX];
                                r_conv_data  <= r_sample;
                                r_state      <= r_cfg[CFG_MSBF_IDX] ? DONE : DATA_LSB;
                                r_cnt        <= CNT_W'(1);
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    DATA_LSB: begin
                        if (w_clk_fall) begin
                            r_miso <= r_sample[r_cnt];
                            if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= DONE;
                            else                             r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (w_clk_fall) r_miso <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.adc_miso    = r_miso;
    assign bus.adc_miso_oe = r_oe;
    assign bus.conv_valid  = r_conv_valid;
    assign bus.conv_ch     = r_conv_ch;
    assign bus.conv_diff   = r_conv_diff;
    assign bus.conv_data   = r_conv_data;
    assign bus.proto_err   = r_proto_err;

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI target that emulates an MCP3202-style 2-channel 12-bit ADC. It is the device end of the adc_clk/adc_cs/adc_mosi/adc_miso link driven by the AUDIO block.
- Used for on-FPGA loopback builds, with a tone generator feeding sample_ch0/1 in place of the external ADC, and as a synthesizable bench target.
- Oversamples the SPI lines on the system clock; no SPI-clock-domain logic.

Parameters:
- DATA_W, 12: conversion width in bits.
- SYNC_STAGES, 2: synchronizer depth on adc_clk, adc_cs and adc_mosi (minimum 2).

Ports:
- clk  in  1  system clock (clk_w, 27 MHz); must be at least 8x adc_clk.
- reset  in  1  synchronous, active-high reset.
- adc_clk  in  1  SPI clock from the master; idles low.
- adc_cs  in  1  active-low chip select.
- adc_mosi  in  1  master data.
- adc_miso  out  1  responder data.
- adc_miso_oe  out  1  output enable for adc_miso; 0 means the top level tri-states the pin.
- sample_ch0  in  DATA_W  unsigned analog value for CH0.
- sample_ch1  in  DATA_W  unsigned analog value for CH1.
- conv_valid  out  1  one-clk pulse when a frame's MSB-first data completes.
- conv_ch  out  1  ODD/SIGN bit of the last frame.
- conv_diff  out  1  1 = the last frame was differential.
- conv_data  out  DATA_W  value shifted out in the last frame.
- proto_err  out  1  one-clk pulse when CS deasserts mid-frame.

Behaviour:
- Reset state:
  - State IDLE; shift registers cleared.
  - adc_miso=0, adc_miso_oe=0, conv_valid=0, proto_err=0, conv_ch=0, conv_diff=0, conv_data=0.
- Edge detection:
  - Rising and falling adc_clk edges are detected on the synchronized signal; latency is SYNC_STAGES+1 clk.
  - adc_cs is synchronized the same way.
  - MOSI is sampled on the detected rising edge.
  - MISO changes only on the detected falling edge, or when CS falls (for the null bit, see CFG below).
- States:
  - IDLE (cs high): oe=0. On synced cs low, go to WAIT_START with oe=1 and miso=0.
  - WAIT_START: leading zeros on rising edges are ignored. The first 1 is the start bit; go to CFG with cnt=0.
  - CFG: capture 3 bits on rising edges, in order SGL/DIFF, ODD/SIGN, MSBF.
    - On the 3rd bit, latch the sample: sgl=1 takes the channel chosen by ODD; sgl=0 takes the difference.
    - Difference is CH0-CH1 when ODD=0 and CH1-CH0 when ODD=1, computed at DATA_W+1 bits and clamped to 0 when negative.
    - Drive the null bit (miso=0) on the next falling edge, then go to DATA_MSB.
  - DATA_MSB: shift out B11..B0, one bit per falling edge. On the falling edge that drives B0, pulse conv_valid and update conv_ch, conv_diff and conv_data. Then go to DATA_LSB if MSBF=0, else DONE.
  - DATA_LSB: shift out B1..B11 LSB-first, one bit per falling edge (B0 is not repeated), then go to DONE.
  - DONE: miso=0 until cs high. Extra clocks are ignored.
- CS deassertion:
  - Synced cs high in any state goes to IDLE next clk with oe=0.
  - If this happens in CFG or DATA_MSB, pulse proto_err.
  - In WAIT_START, DATA_LSB and DONE, deassertion is clean.
- Simultaneous events:
  - A cs rise and an adc_clk edge in the same clk: cs wins, the edge is ignored.
  - A clk edge is never accepted while synced cs is high.
- Reset mid-frame: return to IDLE immediately; no pulses.
- Sample stability: sample_ch0/1 may change at any time. Only the value latched at the MSBF bit is shifted out.

Decomposition:
- Shared package adc_spi_pkg holds:
  - the state enum (IDLE, WAIT_START, CFG, DATA_MSB, DATA_LSB, DONE);
  - DATA_W_DEFAULT=12;
  - the config bit-index constants.
- One sub-module, spi_edge_sync: an N-stage synchronizer with rise/fall pulse outputs, instantiated for adc_clk and adc_cs.

Test Plan:
- Single-ended CH0 read, MSBF=1:
  - Stimulus: sample_ch0=12'hA5C, mosi bits 1,1,0,1 on a 900 kHz clock.
  - Required: null bit then 101001011100; conv_valid with conv_data=12'hA5C, conv_ch=0, conv_diff=0.
- LSB-first tail, MSBF=0:
  - Stimulus: sample_ch1=12'h801, mosi bits 1,1,1,0.
  - Required: MSB stream 100000000001, then 00000000001 (B1..B11); conv_ch=1.
- Differential clamp:
  - Stimulus: ch0=12'h100, ch1=12'h300, SGL=0, ODD=0.
  - Required: data=12'h000.
  - Stimulus: same inputs with ODD=1.
  - Required: data=12'h200.
- Leading zeros and CS abort:
  - Stimulus: five 0 bits before the start bit.
  - Required: frame decodes normally.
  - Stimulus: CS raised after B6.
  - Required: proto_err pulse, no conv_valid, oe=0 within SYNC_STAGES+2 clk.
- Reset and idle:
  - Stimulus: reset asserted mid DATA_MSB.
  - Required: all outputs at reset values the next clk.
  - Stimulus: adc_clk toggling with cs high.
  - Required: oe stays 0, no pulses.
- Back-to-back frames:
  - Stimulus: two frames with 2 adc_clk periods of CS high between them, with the sample changed between frames.
  - Required: the second frame reflects the new sample; both conv_valid pulses are present.
